// File: rtl/object_readout_scheduler_pkg.sv
// Shared widths, reserved label and scan FSM encoding for the object readout scheduler.
package object_readout_scheduler_pkg;

  localparam int LBL_WIDTH      = 8;
  localparam int LOC_SIZE       = 16;
  localparam int RESERVED_LABEL = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_EMIT  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/object_readout_scheduler_if.sv
// Table read port toward the labeller plus the object record valid/ready stream.
interface object_readout_scheduler_if #(
  parameter int LBL_W = object_readout_scheduler_pkg::LBL_WIDTH,
  parameter int LOC_W = object_readout_scheduler_pkg::LOC_SIZE
);

  logic [LBL_W-1:0] obj_id;
  logic [LBL_W-1:0] resolved_id;
  logic [LOC_W-1:0] obj_area;
  logic [LOC_W-1:0] obj_x;
  logic [LOC_W-1:0] obj_y;

  logic             out_valid;
  logic             out_ready;
  logic [LBL_W-1:0] out_label;
  logic [LOC_W-1:0] out_area;
  logic [LOC_W-1:0] out_x;
  logic [LOC_W-1:0] out_y;

  modport master (
    output obj_id, out_valid, out_label, out_area, out_x, out_y,
    input  resolved_id, obj_area, obj_x, obj_y, out_ready
  );

  modport slave (
    input  obj_id, out_valid, out_label, out_area, out_x, out_y,
    output resolved_id, obj_area, obj_x, obj_y, out_ready
  );

endinterface

// File: rtl/object_readout_scheduler.sv
// Post-frame walk of labels 1..num_labels-1, emitting root objects with area >= min_area.
// Costs 2+RD_LATENCY cycles per label; a record stalls the scan until out_ready accepts it.
module object_readout_scheduler
  import object_readout_scheduler_pkg::*;
#(
  parameter int LBL_W      = LBL_WIDTH,
  parameter int LOC_W      = LOC_SIZE,
  parameter int RD_LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_done,
  input  logic [LBL_W-1:0] num_labels,
  input  logic [LOC_W-1:0] min_area,
  object_readout_scheduler_if.master bus,
  output logic             busy,
  output logic             done,
  output logic [LBL_W-1:0] obj_count,
  output logic             overrun
);

  localparam int CNT_W = $clog2(RD_LATENCY) + 1;

  state_t           state, state_nxt;
  logic [LBL_W-1:0] n_lat;
  logic [LOC_W-1:0] thr;
  logic [CNT_W-1:0] wait_cnt;
  logic [LBL_W-1:0] obj_id_q;
  logic             out_valid_q;
  logic [LBL_W-1:0] out_label_q;
  logic [LOC_W-1:0] out_area_q;
  logic [LOC_W-1:0] out_x_q;
  logic [LOC_W-1:0] out_y_q;
  logic [LBL_W-1:0] obj_count_q;
  logic             overrun_q;

  logic keep;
  logic last;
  logic accept;
  logic empty_scan;

  assign keep       = (bus.resolved_id == obj_id_q) && (bus.obj_area >= thr);
  // n_lat of all-ones stops at all-ones minus one, so obj_id never wraps
  assign last       = (obj_id_q == n_lat - LBL_W'(1));
  assign accept     = out_valid_q && bus.out_ready;
  assign empty_scan = (num_labels <= LBL_W'(1));

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (frame_done) state_nxt = empty_scan ? ST_DONE : ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (wait_cnt == '0) state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (keep)      state_nxt = ST_EMIT;
        else if (last) state_nxt = ST_DONE;
        else           state_nxt = ST_ISSUE;
      end
      ST_EMIT:  if (accept) state_nxt = last ? ST_DONE : ST_ISSUE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      n_lat       <= '0;
      thr         <= '0;
      wait_cnt    <= '0;
      obj_id_q    <= LBL_W'(RESERVED_LABEL);
      out_valid_q <= 1'b0;
      out_label_q <= '0;
      out_area_q  <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      obj_count_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_done) begin
            n_lat       <= num_labels;
            thr         <= min_area;
            obj_count_q <= '0;
            overrun_q   <= 1'b0;
            obj_id_q    <= empty_scan ? LBL_W'(RESERVED_LABEL) : LBL_W'(1);
          end
        end
        ST_ISSUE: wait_cnt <= CNT_W'(RD_LATENCY - 1);
        ST_WAIT:  if (wait_cnt != '0) wait_cnt <= wait_cnt - CNT_W'(1);
        ST_CHECK: begin
          if (keep) begin
            out_valid_q <= 1'b1;
            out_label_q <= obj_id_q;
            out_area_q  <= bus.obj_area;
            out_x_q     <= bus.obj_x;
            out_y_q     <= bus.obj_y;
          end else if (!last) begin
            obj_id_q <= obj_id_q + LBL_W'(1);
          end
        end
        ST_EMIT: begin
          if (accept) begin
            out_valid_q <= 1'b0;
            if (obj_count_q != '1) obj_count_q <= obj_count_q + LBL_W'(1);
            if (!last) obj_id_q <= obj_id_q + LBL_W'(1);
          end
        end
        ST_DONE:  obj_id_q <= LBL_W'(RESERVED_LABEL);
        default:  ;
      endcase
      // A start pulse arriving mid-scan, including the DONE cycle, is flagged and dropped
      if (frame_done && (state != ST_IDLE)) overrun_q <= 1'b1;
    end
  end

  assign bus.obj_id    = obj_id_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_label = out_label_q;
  assign bus.out_area  = out_area_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_y     = out_y_q;
  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_DONE);
  assign obj_count     = obj_count_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_object_readout_scheduler.sv
// Bench for object_readout_scheduler: delayed-read table model, directed vector table, random scans.
module tb_object_readout_scheduler;

  localparam int LW  = 4;
  localparam int CW  = 8;
  localparam int RDL = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          frame_done;
  logic [LW-1:0] num_labels;
  logic [CW-1:0] min_area;
  logic          busy;
  logic          done;
  logic [LW-1:0] obj_count;
  logic          overrun;

  always #5 clk = ~clk;

  object_readout_scheduler_if #(.LBL_W(LW), .LOC_W(CW)) bus ();

  object_readout_scheduler #(.LBL_W(LW), .LOC_W(CW), .RD_LATENCY(RDL)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_done (frame_done),
    .num_labels (num_labels),
    .min_area   (min_area),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .obj_count  (obj_count),
    .overrun    (overrun)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Object tables with a fixed read delay of RDL cycles from obj_id
  logic [LW-1:0] res_tab  [16];
  logic [CW-1:0] area_tab [16];
  logic [CW-1:0] x_tab    [16];
  logic [CW-1:0] y_tab    [16];
  logic [LW-1:0] apipe    [RDL];

  always @(posedge clk) begin
    apipe[0] <= bus.obj_id;
    for (int i = 1; i < RDL; i++) apipe[i] <= apipe[i-1];
  end

  assign bus.resolved_id = res_tab[apipe[RDL-1]];
  assign bus.obj_area    = area_tab[apipe[RDL-1]];
  assign bus.obj_x       = x_tab[apipe[RDL-1]];
  assign bus.obj_y       = y_tab[apipe[RDL-1]];

  // out_ready policy: 0 always, 1 random, 2 hold low 5 valid cycles then high, 3 never
  int ready_mode = 0;
  int hold_cnt   = 0;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (hold_cnt >= 5) bus.out_ready = 1'b1;
        else begin
          bus.out_ready = 1'b0;
          if (bus.out_valid) hold_cnt++;
        end
      end
      default: bus.out_ready = 1'b0;
    endcase
  end

  logic [31:0] cur_rec;
  logic [31:0] got [$];
  logic        stall_prev;
  logic [31:0] stall_rec;

  assign cur_rec = {4'b0, bus.out_label, bus.out_area, bus.out_x, bus.out_y};

  always @(negedge clk) begin
    if (!reset_n) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid_held", 32'(bus.out_valid), 32'd1);
        chk("stall_rec_stable", cur_rec, stall_rec);
      end
      if (bus.out_valid && bus.out_ready) got.push_back(cur_rec);
      stall_prev <= bus.out_valid && !bus.out_ready;
      stall_rec  <= cur_rec;
    end
  end

  task automatic load_fixed_tables();
    for (int i = 0; i < 16; i++) begin
      res_tab[i]  = 4'd0;
      area_tab[i] = 8'd0;
      x_tab[i]    = 8'(i * 16 + 1);
      y_tab[i]    = 8'(i * 16 + 9);
    end
    res_tab[1] = 4'd1; area_tab[1] = 8'd10;
    res_tab[2] = 4'd1; area_tab[2] = 8'd5;
    res_tab[3] = 4'd3; area_tab[3] = 8'd7;
  endtask

  // Starts one scan and follows it until four cycles past the first done pulse
  task automatic run_scan(input int n, input int thr, input int mid_at, input bit pulse_on_done,
                          output int dcnt, output int first_done_k);
    int trail;
    got.delete();
    dcnt = 0;
    first_done_k = -1;
    trail = -1;
    @(posedge clk); #1;
    num_labels = n[LW-1:0];
    min_area   = thr[CW-1:0];
    frame_done = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk); #1;
      frame_done = 1'b0;
      if (k == mid_at) begin
        frame_done = 1'b1;
        num_labels = 4'd9;
        min_area   = 8'd200;
      end
      if (done) begin
        dcnt++;
        if (first_done_k < 0) first_done_k = k;
        if (pulse_on_done) frame_done = 1'b1;
        if (trail < 0) trail = 0;
      end
      if (trail >= 0) begin
        trail++;
        if (trail > 4) break;
      end
    end
    frame_done = 1'b0;
    chk("scan_finished", 32'(trail >= 0), 32'd1);
  endtask

  typedef struct {
    int          n;
    int          thr;
    int          mode;
    int          exp_cnt;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int          dcnt;
    int          fk;
    int          n;
    int          thr;
    logic [31:0] expq [$];

    reset_n        = 1'b0;
    frame_done     = 1'b0;
    num_labels     = '0;
    min_area       = '0;
    bus.out_ready  = 1'b0;
    load_fixed_tables();

    vecs[0] = '{1,  0, 0, 0, 32'h000, 32'h000};
    vecs[1] = '{4,  0, 0, 2, 32'h10A, 32'h307};
    vecs[2] = '{4,  0, 2, 2, 32'h10A, 32'h307};
    vecs[3] = '{4,  8, 0, 1, 32'h10A, 32'h000};
    vecs[4] = '{4,  7, 1, 2, 32'h10A, 32'h307};
    vecs[5] = '{4, 11, 0, 0, 32'h000, 32'h000};
    vecs[6] = '{3,  0, 0, 1, 32'h10A, 32'h000};
    vecs[7] = '{0,  0, 0, 0, 32'h000, 32'h000};

    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    chk("rst_obj_id",    32'(bus.obj_id), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_rec",   cur_rec, 32'd0);
    chk("rst_busy",      32'(busy), 32'd0);
    chk("rst_done",      32'(done), 32'd0);
    chk("rst_obj_count", 32'(obj_count), 32'd0);
    chk("rst_overrun",   32'(overrun), 32'd0);

    foreach (vecs[v]) begin
      load_fixed_tables();
      ready_mode = vecs[v].mode;
      hold_cnt   = 0;
      run_scan(vecs[v].n, vecs[v].thr, -1, 1'b0, dcnt, fk);
      chk($sformatf("vec%0d_done_count", v), 32'(dcnt), 32'd1);
      chk($sformatf("vec%0d_obj_count", v), 32'(obj_count), 32'(vecs[v].exp_cnt));
      chk($sformatf("vec%0d_records", v), 32'(got.size()), 32'(vecs[v].exp_cnt));
      if (got.size() > 0 && vecs[v].exp_cnt > 0)
        chk($sformatf("vec%0d_rec0", v), 32'(got[0][27:16]), vecs[v].e0);
      if (got.size() > 1 && vecs[v].exp_cnt > 1)
        chk($sformatf("vec%0d_rec1", v), 32'(got[1][27:16]), vecs[v].e1);
      chk($sformatf("vec%0d_idle_obj_id", v), 32'(bus.obj_id), 32'd0);
      chk($sformatf("vec%0d_idle_busy", v), 32'(busy), 32'd0);
      if (vecs[v].n <= 1)
        chk($sformatf("vec%0d_fast_done", v), 32'(fk <= 1), 32'd1);
    end

    // Mid-scan frame_done: flagged, ignored, scan result unchanged
    load_fixed_tables();
    ready_mode = 0;
    run_scan(4, 0, 5, 1'b0, dcnt, fk);
    chk("mid_overrun",    32'(overrun), 32'd1);
    chk("mid_done_count", 32'(dcnt), 32'd1);
    chk("mid_obj_count",  32'(obj_count), 32'd2);
    chk("mid_records",    32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("mid_rec0", 32'(got[0][27:16]), 32'h10A);
      chk("mid_rec1", 32'(got[1][27:16]), 32'h307);
    end

    // frame_done during the DONE cycle is an overrun, not a restart
    run_scan(4, 0, -1, 1'b1, dcnt, fk);
    chk("donecyc_overrun",    32'(overrun), 32'd1);
    chk("donecyc_no_restart", 32'(busy), 32'd0);
    chk("donecyc_done_count", 32'(dcnt), 32'd1);

    run_scan(1, 0, -1, 1'b0, dcnt, fk);
    chk("overrun_cleared", 32'(overrun), 32'd0);

    // Reset while a record is waiting in EMIT
    ready_mode = 3;
    @(posedge clk); #1;
    num_labels = 4'd4;
    min_area   = 8'd0;
    frame_done = 1'b1;
    @(posedge clk); #1;
    frame_done = 1'b0;
    for (int k = 0; k < 50 && !bus.out_valid; k++) begin
      @(posedge clk); #1;
    end
    chk("emit_reached", 32'(bus.out_valid), 32'd1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("emit_rst_valid",  32'(bus.out_valid), 32'd0);
    chk("emit_rst_busy",   32'(busy), 32'd0);
    chk("emit_rst_obj_id", 32'(bus.obj_id), 32'd0);
    chk("emit_rst_count",  32'(obj_count), 32'd0);
    reset_n = 1'b1;

    // Random tables, thresholds and backpressure against a filtering model
    for (int s = 0; s < 25; s++) begin
      for (int i = 0; i < 16; i++) begin
        res_tab[i]  = ($urandom_range(0, 1) != 0) ? i[LW-1:0] : 4'($urandom_range(0, 15));
        area_tab[i] = 8'($urandom_range(0, 255));
        x_tab[i]    = 8'($urandom_range(0, 255));
        y_tab[i]    = 8'($urandom_range(0, 255));
      end
      n   = (s == 0) ? 15 : $urandom_range(0, 15);
      thr = $urandom_range(0, 180);
      ready_mode = $urandom_range(0, 1);
      expq.delete();
      for (int i = 1; i < n; i++)
        if (res_tab[i] == i[LW-1:0] && area_tab[i] >= thr[CW-1:0])
          expq.push_back({4'b0, i[LW-1:0], area_tab[i], x_tab[i], y_tab[i]});
      run_scan(n, thr, -1, 1'b0, dcnt, fk);
      chk($sformatf("rnd%0d_records", s), 32'(got.size()), 32'(expq.size()));
      for (int i = 0; i < expq.size() && i < got.size(); i++)
        chk($sformatf("rnd%0d_rec%0d", s, i), got[i], expq[i]);
      chk($sformatf("rnd%0d_obj_count", s), 32'(obj_count), 32'(expq.size()));
      chk($sformatf("rnd%0d_done_count", s), 32'(dcnt), 32'd1);
      chk($sformatf("rnd%0d_idle_obj_id", s), 32'(bus.obj_id), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
